hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RISC-V pipeline with BTB.
- Drives en/clear of every segment register (IF PC, ID, EX, MEM, WB): en = ~StallX, clear = FlushX.
- Owns the data-cache miss handshake FSM and resolves load-use hazards, branch/jalr redirects and BTB mispredicts.
- Keeps saturating performance counters for branch-prediction evaluation.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard / stall-flush controller.
package hazard_pkg;

    localparam logic [1:0] MEM2REG_MEM = 2'b01;

    localparam logic [1:0] NPC_NONE = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_PC4  = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FILL = 2'd2
    } miss_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: D-cache miss freeze,
// load-use bubbles, EX redirects and branch-prediction statistics.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [1:0]       RegReadD,
    input  logic [4:0]       RdE,
    input  logic [1:0]       MemToRegE,
    input  logic [2:0]       BranchTypeE,
    input  logic             BrTakenE,
    input  logic             BRPredictedE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic             BRPredictedD,
    input  logic             DCacheMissM,
    input  logic             MemAccessM,
    input  logic             mem_ack,
    input  logic             clear_stats,
    output logic             mem_req,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       NpcSelE,
    output logic             miss_timeout_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TW = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);

    miss_state_e   state, state_nxt;
    logic [TW-1:0] wait_cnt;
    logic          load_use, mis, jal_redirect, idle;

    assign idle = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (DCacheMissM && MemAccessM) state_nxt = WAIT;
            WAIT:    if (mem_ack) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The error flag is raised on the edge where the WAIT count reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt         <= '0;
            miss_timeout_err <= 1'b0;
        end else if (state == WAIT) begin
            if (wait_cnt != TW'(MISS_TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == TW'(MISS_TIMEOUT - 1))
                miss_timeout_err <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign load_use = (MemToRegE == MEM2REG_MEM) && (RdE != 5'd0) &&
                      ((RegReadD[1] && (Rs1D == RdE)) || (RegReadD[0] && (Rs2D == RdE)));
    assign mis          = ((BranchTypeE != 3'd0) && (BrTakenE != BRPredictedE)) || JalrE;
    assign jal_redirect = JalD && !BRPredictedD;

    always_comb begin
        mem_req = (state == WAIT);
        {StallF, StallD, StallE, StallM, StallW} = 5'b0;
        {FlushD, FlushE, FlushM, FlushW}         = 4'b0;
        NpcSelE = NPC_NONE;
        if (!rst_n) begin
            {FlushD, FlushE, FlushM, FlushW} = 4'b1111;
        end else if (!idle) begin
            {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
        end else if (mis) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            if (JalrE)         NpcSelE = NPC_JALR;
            else if (BrTakenE) NpcSelE = NPC_BR;
            else               NpcSelE = NPC_PC4;
        end else if (load_use) begin
            // The stalled jal stays in ID; its redirect happens once the bubble drains.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (jal_redirect) begin
            FlushD = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk(clk), .rst_n(rst_n),
        .inc((BranchTypeE != 3'd0) && idle && !StallE),
        .clr(clear_stats), .cnt(branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .clk(clk), .rst_n(rst_n),
        .inc(mis && idle), .clr(clear_stats), .cnt(mispredict_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n),
        .inc(StallF), .clr(clear_stats), .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic [1:0]  RegReadD, MemToRegE;
    logic [2:0]  BranchTypeE;
    logic        BrTakenE, BRPredictedE, JalrE, JalD, BRPredictedD;
    logic        DCacheMissM, MemAccessM, mem_ack, clear_stats;
    logic        mem_req, StallF, StallD, StallE, StallM, StallW;
    logic        FlushD, FlushE, FlushM, FlushW, miss_timeout_err;
    logic [1:0]  NpcSelE;
    logic [31:0] branch_cnt, mispredict_cnt, stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    hazard_ctrl #(.CNT_W(32), .MISS_TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD), .RdE(RdE),
        .MemToRegE(MemToRegE), .BranchTypeE(BranchTypeE), .BrTakenE(BrTakenE),
        .BRPredictedE(BRPredictedE), .JalrE(JalrE), .JalD(JalD),
        .BRPredictedD(BRPredictedD), .DCacheMissM(DCacheMissM),
        .MemAccessM(MemAccessM), .mem_ack(mem_ack), .clear_stats(clear_stats),
        .mem_req(mem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
        .FlushM(FlushM), .FlushW(FlushW), .NpcSelE(NpcSelE),
        .miss_timeout_err(miss_timeout_err), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        Rs1D = 0; Rs2D = 0; RdE = 0; RegReadD = 0; MemToRegE = 0;
        BranchTypeE = 0; BrTakenE = 0; BRPredictedE = 0; JalrE = 0;
        JalD = 0; BRPredictedD = 0; DCacheMissM = 0; MemAccessM = 0;
        mem_ack = 0; clear_stats = 0;
    endtask

    function automatic logic [4:0] stalls();
        return {StallF, StallD, StallE, StallM, StallW};
    endfunction

    function automatic logic [3:0] flushes();
        return {FlushD, FlushE, FlushM, FlushW};
    endfunction

    // A stage must never be cleared while it is held.
    always @(negedge clk)
        chk("inv_stall_flush", {28'b0, StallD & FlushD, StallE & FlushE,
                                 StallM & FlushM, StallW & FlushW}, 32'd0);

    initial begin
        clr_in();
        rst_n = 1'b0;
        #12;
        chk("rst_flush", flushes(), 4'b1111);
        chk("rst_stall", stalls(), 5'b0);
        chk("rst_memreq", mem_req, 0);
        rst_n = 1'b1;
        tick();

        // Reset while waiting on a refill
        DCacheMissM = 1; MemAccessM = 1;
        tick();
        DCacheMissM = 0; MemAccessM = 0;
        chk("wait_memreq", mem_req, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw_memreq", mem_req, 0);
        chk("rstw_flush", flushes(), 4'b1111);
        chk("rstw_stall", stalls(), 5'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("rstw_idle_stall", stalls(), 5'b0);
        chk("rstw_idle_memreq", mem_req, 0);
        chk("rstw_stall_cnt", stall_cnt, 0);
        chk("rstw_branch_cnt", branch_cnt, 0);
        chk("rstw_mis_cnt", mispredict_cnt, 0);

        // Load-use on rs1
        MemToRegE = 2'b01; RdE = 5; Rs1D = 5; RegReadD = 2'b10;
        #1;
        chk("lu_sfd_fe", {StallF, StallD, FlushE}, 3'b111);
        chk("lu_flushd", FlushD, 0);
        tick();
        clr_in();
        #1;
        chk("lu_release", StallF, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        MemToRegE = 2'b01; RdE = 0; Rs1D = 0; RegReadD = 2'b10;
        #1;
        chk("lu_x0_stall", {StallF, StallD, FlushE}, 3'b000);
        tick();
        clr_in();
        chk("lu_x0_cnt", stall_cnt, 1);

        // Taken branch not predicted
        BranchTypeE = 3'b001; BrTakenE = 1; BRPredictedE = 0;
        #1;
        chk("br_mis_flush", {FlushD, FlushE}, 2'b11);
        chk("br_mis_npc", NpcSelE, 2'b01);
        tick();
        clr_in();
        chk("br_mis_cnt", mispredict_cnt, 1);
        chk("br_br_cnt", branch_cnt, 1);
        BranchTypeE = 3'b001; BrTakenE = 1; BRPredictedE = 1;
        #1;
        chk("br_ok_flush", flushes(), 4'b0);
        chk("br_ok_npc", NpcSelE, 2'b00);
        tick();
        clr_in();
        chk("br_ok_br_cnt", branch_cnt, 2);
        chk("br_ok_mis_cnt", mispredict_cnt, 1);

        // Mispredict beats load-use
        BranchTypeE = 3'b001; BrTakenE = 1; BRPredictedE = 0;
        MemToRegE = 2'b01; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
        #1;
        chk("mlu_flush", {FlushD, FlushE}, 2'b11);
        chk("mlu_stallf", {StallF, StallD}, 2'b00);
        chk("mlu_npc", NpcSelE, 2'b01);
        tick();
        clr_in();
        chk("mlu_mis_cnt", mispredict_cnt, 2);
        chk("mlu_stall_cnt", stall_cnt, 1);

        // jal alone, then jal with predicted-but-not-taken branch
        JalD = 1; BRPredictedD = 0;
        #1;
        chk("jal_flush", flushes(), 4'b1000);
        chk("jal_npc", NpcSelE, 2'b00);
        BranchTypeE = 3'b010; BrTakenE = 0; BRPredictedE = 1;
        #1;
        chk("jal_br_flush", {FlushD, FlushE}, 2'b11);
        chk("jal_br_npc", NpcSelE, 2'b10);
        tick();
        clr_in();
        chk("jal_br_mis_cnt", mispredict_cnt, 3);
        chk("jal_br_br_cnt", branch_cnt, 4);

        // Miss with 4-cycle ack, jalr waiting in EX
        DCacheMissM = 1; MemAccessM = 1;
        #1;
        chk("miss_idle_stall", stalls(), 5'b0);
        tick();
        DCacheMissM = 0; MemAccessM = 0; JalrE = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("miss_memreq", mem_req, 1);
            chk("miss_stall", stalls(), 5'b11111);
            chk("miss_flush", flushes(), 4'b0);
            chk("miss_npc", NpcSelE, 2'b00);
            if (i == 3) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        #1;
        chk("fill_memreq", mem_req, 0);
        chk("fill_stall", stalls(), 5'b11111);
        tick();
        chk("post_npc", NpcSelE, 2'b11);
        chk("post_stall", stalls(), 5'b0);
        chk("post_flush", {FlushD, FlushE}, 2'b11);
        chk("post_stall_cnt", stall_cnt, 6);
        chk("post_err", miss_timeout_err, 1);
        tick();
        clr_in();
        chk("post_mis_cnt", mispredict_cnt, 4);

        // clear_stats beats increment
        BranchTypeE = 3'b001; BrTakenE = 1; BRPredictedE = 0; clear_stats = 1;
        tick();
        clr_in();
        chk("clr_branch", branch_cnt, 0);
        chk("clr_mis", mispredict_cnt, 0);
        chk("clr_stall", stall_cnt, 0);

        // Timeout: 10 WAIT cycles with no ack
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("to_err_rst", miss_timeout_err, 0);
        tick();
        DCacheMissM = 1; MemAccessM = 1;
        tick();
        DCacheMissM = 0; MemAccessM = 0;
        for (int i = 0; i < 10; i++) begin
            chk("to_memreq", mem_req, 1);
            chk("to_err", miss_timeout_err, (i >= 3) ? 32'd1 : 32'd0);
            tick();
        end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("to_fill_err", miss_timeout_err, 1);
        tick();
        chk("to_idle_memreq", mem_req, 0);
        chk("to_idle_err", miss_timeout_err, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
